// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// aes_round_sequencer : sequences one AES-128 block through an external round
//                       datapath using FIFO-fed state and pre-expanded keys.
// Revision 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
  parameter int NR     = 10,
  parameter int DATA_W = 128
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] in_state_i,
  input  logic              in_state_empty_i,
  output logic              in_state_rd_o,
  input  logic [DATA_W-1:0] round_key_i,
  input  logic              key_empty_i,
  output logic              key_rd_o,
  output logic [DATA_W-1:0] rnd_state_o,
  output logic [DATA_W-1:0] rnd_key_o,
  output logic              rnd_last_o,
  output logic              rnd_start_o,
  input  logic [DATA_W-1:0] rnd_result_i,
  input  logic              rnd_done_i,
  output logic [DATA_W-1:0] out_state_o,
  input  logic              out_state_full_i,
  output logic              out_state_wr_o,
  output logic              busy_o,
  output logic [3:0]        round_cnt_o,
  output logic              proto_err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  localparam logic [3:0] C_LAST_ROUND = 4'(NR);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] blk_q, blk_d;
  logic [DATA_W-1:0] rnd_state_q, rnd_state_d;
  logic [DATA_W-1:0] rnd_key_q, rnd_key_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              rnd_last_q, rnd_last_d;
  logic              perr_q, perr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              in_rd, key_rd, out_wr, start;

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    rnd_state_d = rnd_state_q;
    rnd_key_d   = rnd_key_q;
    rnd_last_d  = rnd_last_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    in_rd       = 1'b0;
    key_rd      = 1'b0;
    out_wr      = 1'b0;
    start       = 1'b0;
    perr_d      = perr_q | (rnd_done_i && (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        // Initial AddRoundKey is folded into the pop of the first key.
        if (!in_state_empty_i && !key_empty_i) begin
          in_rd   = 1'b1;
          key_rd  = 1'b1;
          blk_d   = in_state_i ^ round_key_i;
          cnt_d   = 4'd1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!key_empty_i) begin
          key_rd      = 1'b1;
          rnd_key_d   = round_key_i;
          rnd_state_d = blk_q;
          rnd_last_d  = (cnt_q == C_LAST_ROUND);
          state_d     = S_START;
        end
      end
      S_START: begin
        start   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rnd_done_i) begin
          blk_d = rnd_result_i;
          if (cnt_q == C_LAST_ROUND) begin
            out_d   = rnd_result_i;
            state_d = S_WRITE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_WRITE: begin
        if (!out_state_full_i) begin
          out_wr  = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      blk_q       <= '0;
      rnd_state_q <= '0;
      rnd_key_q   <= '0;
      rnd_last_q  <= 1'b0;
      out_q       <= '0;
      cnt_q       <= 4'd0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      rnd_state_q <= rnd_state_d;
      rnd_key_q   <= rnd_key_d;
      rnd_last_q  <= rnd_last_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      perr_q      <= perr_d;
    end
  end

  // Gating with reset makes every output read 0 during the reset cycle itself.
  assign in_state_rd_o  = reset_i & in_rd;
  assign key_rd_o       = reset_i & key_rd;
  assign out_state_wr_o = reset_i & out_wr;
  assign rnd_start_o    = reset_i & start;
  assign rnd_state_o    = {DATA_W{reset_i}} & rnd_state_q;
  assign rnd_key_o      = {DATA_W{reset_i}} & rnd_key_q;
  assign rnd_last_o     = reset_i & rnd_last_q;
  assign out_state_o    = {DATA_W{reset_i}} & out_q;
  assign busy_o         = reset_i & (state_q != S_IDLE);
  assign round_cnt_o    = {4{reset_i}} & cnt_q;
  assign proto_err_o    = reset_i & perr_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// tb_aes_round_sequencer : self-checking bench with FIFO/datapath models and
//                          a behavioural AES-128 reference.
// Revision 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;
  localparam int NR = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n      = 1'b0;
  logic [127:0] in_state   = '0;
  logic [127:0] round_key  = '0;
  logic [127:0] rnd_result = '0;
  logic         in_empty   = 1'b1;
  logic         key_empty  = 1'b1;
  logic         rnd_done   = 1'b0;
  logic         out_full   = 1'b0;
  logic         in_rd, key_rd, rnd_last, rnd_start, out_wr, busy, proto_err;
  logic [127:0] rnd_state, rnd_key, out_state;
  logic [3:0]   round_cnt;

  aes_round_sequencer #(.NR(NR), .DATA_W(128)) dut (
    .clock_i         (clk),
    .reset_i         (rst_n),
    .in_state_i      (in_state),
    .in_state_empty_i(in_empty),
    .in_state_rd_o   (in_rd),
    .round_key_i     (round_key),
    .key_empty_i     (key_empty),
    .key_rd_o        (key_rd),
    .rnd_state_o     (rnd_state),
    .rnd_key_o       (rnd_key),
    .rnd_last_o      (rnd_last),
    .rnd_start_o     (rnd_start),
    .rnd_result_i    (rnd_result),
    .rnd_done_i      (rnd_done),
    .out_state_o     (out_state),
    .out_state_full_i(out_full),
    .out_state_wr_o  (out_wr),
    .busy_o          (busy),
    .round_cnt_o     (round_cnt),
    .proto_err_o     (proto_err)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural AES-128 -----------------------------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) b[rw+4*c] = a[rw+4*((c+rw)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = gm(x0, 8'd2) ^ gm(x1, 8'd3) ^ x2 ^ x3;
        b[4*c+1] = x0 ^ gm(x1, 8'd2) ^ gm(x2, 8'd3) ^ x3;
        b[4*c+2] = x0 ^ x1 ^ gm(x2, 8'd2) ^ gm(x3, 8'd3);
        b[4*c+3] = gm(x0, 8'd3) ^ x1 ^ x2 ^ gm(x3, 8'd2);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] rkey(input logic [127:0] key, input int rn);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*rn], w[4*rn+1], w[4*rn+2], w[4*rn+3]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s;
    s = pt ^ rkey(key, 0);
    for (int rn = 1; rn <= NR; rn++) s = aes_round(s, rkey(key, rn), rn == NR);
    return s;
  endfunction

  // ---------------- FIFO and datapath environment -------------------------
  logic [127:0] in_q[$];
  logic [127:0] key_q[$];
  logic [127:0] got[$];
  int           lat = 1;
  bit           rand_lat = 1'b0;
  logic         inject_done = 1'b0;

  logic s_in_rd = 0, s_key_rd = 0, s_start = 0, s_rst_n = 0;
  logic [127:0] cap_state, cap_key, dp_res;
  logic         cap_last;
  int           dp_cnt = 0;
  bit           dp_busy = 1'b0, dp_fire = 1'b0;
  int           rd_cyc = -1, wr_cyc = -1, last_wr_cyc = -1;
  int           start_idx = 0, key_rd_cnt = 0;

  always @(negedge clk) begin
    s_in_rd  = in_rd;
    s_key_rd = key_rd;
    s_start  = rnd_start;
    s_rst_n  = rst_n;
    if (in_rd) begin
      chk("in_rd_while_empty", in_empty, 1'b0);
      if (last_wr_cyc >= 0) chk("rd_after_wr", cyc > last_wr_cyc, 1'b1);
      rd_cyc    = cyc;
      start_idx = 0;
    end
    if (key_rd) begin
      chk("key_rd_while_empty", key_empty, 1'b0);
      key_rd_cnt++;
    end
    if (out_wr) begin
      chk("wr_while_full", out_full, 1'b0);
      got.push_back(out_state);
      wr_cyc      = cyc;
      last_wr_cyc = cyc;
    end
    if (rnd_start) begin
      start_idx++;
      chk("rnd_last_flag", rnd_last, start_idx == NR);
    end
    if (dp_busy) begin
      chk("dp_state_stable", rnd_state, cap_state);
      chk("dp_key_stable", rnd_key, cap_key);
      chk("dp_last_stable", rnd_last, cap_last);
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (dp_fire) dp_busy = 1'b0;
    dp_fire = 1'b0;
    if (!s_rst_n) begin
      dp_cnt  = 0;
      dp_busy = 1'b0;
    end else begin
      if (s_start) begin
        cap_state = rnd_state;
        cap_key   = rnd_key;
        cap_last  = rnd_last;
        dp_res    = aes_round(rnd_state, rnd_key, rnd_last);
        dp_cnt    = rand_lat ? int'($urandom_range(1, 8)) : lat;
        dp_busy   = 1'b1;
      end
      if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) dp_fire = 1'b1;
      end
    end
    if (s_in_rd && in_q.size() > 0) void'(in_q.pop_front());
    if (s_key_rd && key_q.size() > 0) void'(key_q.pop_front());
    in_empty   = (in_q.size() == 0);
    in_state   = in_empty ? '0 : in_q[0];
    key_empty  = (key_q.size() == 0);
    round_key  = key_empty ? '0 : key_q[0];
    rnd_done   = dp_fire | inject_done;
    rnd_result = dp_fire ? dp_res : '0;
  end

  // ---------------- helpers ------------------------------------------------
  task automatic push_block(input logic [127:0] pt, input logic [127:0] key, input int nkeys);
    in_q.push_back(pt);
    for (int rn = 0; rn < nkeys; rn++) key_q.push_back(rkey(key, rn));
  endtask

  task automatic expect_ct(input string name, input logic [127:0] exp);
    int t = 0;
    logic [127:0] v;
    while (got.size() == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (got.size() == 0) v = 'x;
    else v = got.pop_front();
    chk(name, v, exp);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_rnd_state"}, rnd_state, '0);
    chk({name, "_rnd_key"}, rnd_key, '0);
    chk({name, "_out_state"}, out_state, '0);
    chk({name, "_ctrl"}, {in_rd, key_rd, out_wr, rnd_start, rnd_last, busy, proto_err, round_cnt}, '0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int           lat;
    int           exp_lat;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
    $fatal(1);
  end

  // ---------------- main test ---------------------------------------------
  initial begin
    vec_t         vecs [4];
    logic [127:0] p1, k1, p2, k2, exp1, exp2;
    int           k0, t, ngot;

    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 31};
    vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 1, 31};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2, 41};
    vecs[3] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 51};
    build_sbox();

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, round_cnt, proto_err}, '0);

    // Known-answer vectors with fixed datapath latency.
    for (int i = 0; i < 4; i++) begin
      lat    = vecs[i].lat;
      rd_cyc = -1;
      k0     = key_rd_cnt;
      push_block(vecs[i].pt, vecs[i].key, NR + 1);
      expect_ct($sformatf("kat%0d_ct", i), vecs[i].ct);
      chk($sformatf("kat%0d_latency", i), 128'(wr_cyc - rd_cyc), 128'(vecs[i].exp_lat));
      chk($sformatf("kat%0d_keys", i), 128'(key_rd_cnt - k0), 128'(NR + 1));
    end
    chk("no_proto_err", proto_err, 1'b0);
    lat = 1;

    // Key FIFO underflow after round 4's key: 7-cycle stall in ISSUE.
    p1 = rnd128(); k1 = rnd128(); exp1 = aes_enc(p1, k1);
    rd_cyc = -1;
    k0 = key_rd_cnt;
    push_block(p1, k1, 5);
    t = 0;
    while (!(busy && round_cnt == 4'd5) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("underflow_reach_r5", {busy, round_cnt}, {1'b1, 4'd5});
    for (int i = 0; i < 7; i++) begin
      chk("stall_no_start", rnd_start, 1'b0);
      chk("stall_no_key_rd", key_rd, 1'b0);
      if (i < 6) @(negedge clk);
    end
    for (int rn = 5; rn <= NR; rn++) key_q.push_back(rkey(k1, rn));
    expect_ct("underflow_ct", exp1);
    chk("underflow_latency", 128'(wr_cyc - rd_cyc), 128'(31 + 7));
    chk("underflow_keys", 128'(key_rd_cnt - k0), 128'(NR + 1));

    // Output FIFO full for the first 5 cycles of WRITE.
    @(posedge clk); #1; out_full = 1'b1;
    @(negedge clk);
    p1 = rnd128(); k1 = rnd128(); exp1 = aes_enc(p1, k1);
    rd_cyc = -1;
    push_block(p1, k1, NR + 1);
    t = 0;
    while (!(rd_cyc >= 0 && cyc == rd_cyc + 31) && t < 500) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("full_no_wr", out_wr, 1'b0);
      chk("full_out_stable", out_state, exp1);
      chk("full_busy", busy, 1'b1);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1; out_full = 1'b0;
    expect_ct("full_ct", exp1);
    chk("full_latency", 128'(wr_cyc - rd_cyc), 128'(36));

    // Back-to-back random blocks with random datapath latency.
    rand_lat = 1'b1;
    for (int it = 0; it < 3; it++) begin
      @(negedge clk);
      p1 = rnd128(); k1 = rnd128(); p2 = rnd128(); k2 = rnd128();
      exp1 = aes_enc(p1, k1);
      exp2 = aes_enc(p2, k2);
      push_block(p1, k1, NR + 1);
      push_block(p2, k2, NR + 1);
      expect_ct($sformatf("rand%0d_first", it), exp1);
      expect_ct($sformatf("rand%0d_second", it), exp2);
    end
    rand_lat = 1'b0;
    chk("rand_no_proto_err", proto_err, 1'b0);

    // Spurious done while idle, then during START.
    @(posedge clk); #1; inject_done = 1'b1;
    @(posedge clk); #1; inject_done = 1'b0;
    @(negedge clk);
    chk("spur_idle_perr", proto_err, 1'b1);
    chk("spur_idle_busy", busy, 1'b0);
    p1 = rnd128(); k1 = rnd128(); exp1 = aes_enc(p1, k1);
    push_block(p1, k1, NR + 1);
    t = 0;
    while (!in_rd && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1; inject_done = 1'b1;
    @(negedge clk);
    chk("spur_in_start", rnd_start, 1'b1);
    @(posedge clk); #1; inject_done = 1'b0;
    expect_ct("spur_ct", exp1);
    chk("spur_perr_sticky", proto_err, 1'b1);

    // Reset pulse during round 6 aborts the block.
    @(negedge clk);
    p1 = rnd128(); k1 = rnd128();
    push_block(p1, k1, NR + 1);
    t = 0;
    while (!(busy && round_cnt == 4'd6) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_r6", {busy, round_cnt}, {1'b1, 4'd6});
    ngot = got.size();
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    in_q.delete();
    key_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {busy, round_cnt, proto_err}, '0);
    repeat (40) @(negedge clk);
    chk("abort_no_write", 128'(got.size()), 128'(ngot));
    p2 = rnd128(); k2 = rnd128(); exp2 = aes_enc(p2, k2);
    rd_cyc = -1;
    push_block(p2, k2, NR + 1);
    expect_ct("after_abort_ct", exp2);
    chk("after_abort_latency", 128'(wr_cyc - rd_cyc), 128'(31));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
